// File: rtl/wb_pkg.sv
// ---------------------------------------------------------------------------
// wb_pkg
//   Shared types and constants for the register-file write-back block.
//   XLEN       : data width of every register-file write.
//   REG_ADDR_W : width of an RV32 register index.
//   wb_entry_t : one pending write {rd, data}.
//   wb_src_e   : which producer was selected for the write this cycle.
// ---------------------------------------------------------------------------
package wb_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        WB_NONE   = 2'd0,
        WB_ALU    = 2'd1,
        WB_FIFO   = 2'd2,
        WB_BYPASS = 2'd3
    } wb_src_e;

endpackage

// File: rtl/regfile_writeback_if.sv
// ---------------------------------------------------------------------------
// regfile_writeback_if
//   Long-path (load/store, mul/div) result channel.
//   valid : producer offers {rd, data}
//   ready : write-back can take the offer this cycle
//   rd    : destination register
//   data  : result
//   Handshake: a transfer happens on a rising edge where valid && ready.
//   ready depends only on write-back state, never on valid. While valid is
//   high and ready low, the producer keeps rd and data stable.
//   master : producer side; slave : write-back side.
// ---------------------------------------------------------------------------
interface regfile_writeback_if;
    import wb_pkg::*;

    logic                  valid;
    logic                  ready;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;

    modport master (output valid, output rd, output data, input ready);
    modport slave  (input valid, input rd, input data, output ready);

endinterface

// File: rtl/wb_fifo.sv
// ---------------------------------------------------------------------------
// wb_fifo
//   Small synchronous FIFO of wb_entry_t for long-path results that could
//   not be written immediately.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push, din  : enqueue din (ignored when full)
//   pop        : dequeue head (ignored when empty)
//   full/empty : occupancy flags
//   head       : oldest entry, valid when !empty
//   DEPTH must be a power of two, at least 2.
// ---------------------------------------------------------------------------
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  logic      pop,
    input  wb_entry_t din,
    output logic      full,
    output logic      empty,
    output wb_entry_t head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = 1;

    wb_entry_t      mem [DEPTH];
    // The extra MSB flips on every wrap, so equal low bits with different
    // MSBs means full, fully equal pointers mean empty.
    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage needs no reset: nothing is read until the pointers say so.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PTR_W-1:0]] <= din;
    end

endmodule

// File: rtl/regfile_writeback.sv
// ---------------------------------------------------------------------------
// regfile_writeback
//   Write-side driver of the RV32 integer register file. Merges the
//   single-cycle ALU result (no backpressure) with long-path results
//   (valid/ready, buffered in a FIFO) and registers the selected write.
//   Also keeps a pending-write scoreboard used by decode to stall.
//
//   i_clk, i_rst_n   : clock, asynchronous active-low reset
//   i_issue_valid    : decode issued an instruction this cycle
//   i_issue_long     : ... and it completes on the long path
//   i_issue_rd       : its destination register
//   i_alu_valid/rd/data : ALU result, always accepted
//   lsu (slave)      : long-path result channel; lsu.ready = FIFO not full
//   o_waddr/o_wdata  : registered write address/data (held when idle)
//   o_write          : registered write enable
//   o_busy           : bit n set -> xn has a pending long-path write
//
//   Priority each cycle: ALU, then FIFO head, then direct bypass of a
//   long-path transfer. Writes to x0 are dropped but still consume their
//   source. Outputs appear one edge after selection.
//
//   Optional macro WB_FORWARD_EN adds o_fwd_valid/o_fwd_rd/o_fwd_data, a
//   combinational copy of this cycle's selected write for early bypass.
// ---------------------------------------------------------------------------
module regfile_writeback
    import wb_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_issue_valid,
    input  logic                  i_issue_long,
    input  logic [REG_ADDR_W-1:0] i_issue_rd,
    input  logic                  i_alu_valid,
    input  logic [REG_ADDR_W-1:0] i_alu_rd,
    input  logic [XLEN-1:0]       i_alu_data,
    regfile_writeback_if.slave    lsu,
    output logic [REG_ADDR_W-1:0] o_waddr,
    output logic [XLEN-1:0]       o_wdata,
    output logic                  o_write,
    output logic [NUM_REGS-1:0]   o_busy
`ifdef WB_FORWARD_EN
    ,
    output logic                  o_fwd_valid,
    output logic [REG_ADDR_W-1:0] o_fwd_rd,
    output logic [XLEN-1:0]       o_fwd_data
`endif
);

    wb_src_e             sel_src;
    wb_entry_t           sel_entry;
    wb_entry_t           lsu_entry;
    wb_entry_t           fifo_head;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_push;
    logic                fifo_pop;
    logic                lsu_fire;
    logic                sel_write;
    logic                sel_long;
    logic                busy_set;
    logic [NUM_REGS-1:0] busy_d;

    assign lsu.ready = !fifo_full;
    assign lsu_fire  = lsu.valid && !fifo_full;
    assign lsu_entry = '{rd: lsu.rd, data: lsu.data};

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (lsu_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    // Source selection. An accepted long-path result that is not bypassed
    // always goes into the FIFO, so acceptance order is commit order.
    always_comb begin
        sel_src   = WB_NONE;
        sel_entry = '0;
        fifo_push = 1'b0;
        fifo_pop  = 1'b0;
        if (i_alu_valid) begin
            sel_src   = WB_ALU;
            sel_entry = '{rd: i_alu_rd, data: i_alu_data};
            fifo_push = lsu_fire;
        end else if (!fifo_empty) begin
            sel_src   = WB_FIFO;
            sel_entry = fifo_head;
            fifo_pop  = 1'b1;
            fifo_push = lsu_fire;
        end else if (lsu_fire) begin
            sel_src   = WB_BYPASS;
            sel_entry = lsu_entry;
        end
    end

    assign sel_write = (sel_src != WB_NONE) && (sel_entry.rd != '0);
    assign sel_long  = (sel_src == WB_FIFO) || (sel_src == WB_BYPASS);
    assign busy_set  = i_issue_valid && i_issue_long && (i_issue_rd != '0);

    // Clear first, then set, so a same-cycle set on the same rd wins.
    always_comb begin
        busy_d = o_busy;
        if (sel_long) busy_d[sel_entry.rd] = 1'b0;
        if (busy_set) busy_d[i_issue_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_write <= 1'b0;
            o_waddr <= '0;
            o_wdata <= '0;
            o_busy  <= '0;
        end else begin
            o_write <= sel_write;
            if (sel_write) begin
                o_waddr <= sel_entry.rd;
                o_wdata <= sel_entry.data;
            end
            o_busy <= busy_d;
        end
    end

`ifdef WB_FORWARD_EN
    assign o_fwd_valid = sel_write;
    assign o_fwd_rd    = sel_entry.rd;
    assign o_fwd_data  = sel_entry.data;
`endif

    // Decode must not issue a second long op to a register still pending,
    // unless that pending write commits in this very cycle.
    a_no_double_issue : assert property (
        @(posedge i_clk) disable iff (!i_rst_n)
        (busy_set && !(sel_long && sel_entry.rd == i_issue_rd)) |-> !o_busy[i_issue_rd]
    ) else $error("long op issued to busy register x%0d", i_issue_rd);

endmodule

// File: tb/tb_regfile_writeback.sv
// ---------------------------------------------------------------------------
// tb_regfile_writeback
//   Directed scenarios followed by randomized traffic, checked each cycle
//   against a queue-based reference model of the write-back rules.
// ---------------------------------------------------------------------------
module tb_regfile_writeback;
    import wb_pkg::*;

    localparam int DEPTH = 2;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    logic        issue_valid, issue_long;
    logic [4:0]  issue_rd;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        write;
    logic [31:0] busy;
`ifdef WB_FORWARD_EN
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
`endif

    regfile_writeback_if lsu_if ();

    regfile_writeback #(.FIFO_DEPTH(DEPTH)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_issue_valid (issue_valid),
        .i_issue_long  (issue_long),
        .i_issue_rd    (issue_rd),
        .i_alu_valid   (alu_valid),
        .i_alu_rd      (alu_rd),
        .i_alu_data    (alu_data),
        .lsu           (lsu_if),
        .o_waddr       (waddr),
        .o_wdata       (wdata),
        .o_write       (write),
        .o_busy        (busy)
`ifdef WB_FORWARD_EN
        ,
        .o_fwd_valid   (fwd_valid),
        .o_fwd_rd      (fwd_rd),
        .o_fwd_data    (fwd_data)
`endif
    );

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [36:0] m_q[$];      // pending long-path results {rd, data}, oldest first
    logic [31:0] m_busy  = '0;
    logic        m_write = 1'b0;
    logic [4:0]  m_waddr = '0;
    logic [31:0] m_wdata = '0;

    task automatic model_reset();
        m_q.delete();
        m_busy  = '0;
        m_write = 1'b0;
        m_waddr = '0;
        m_wdata = '0;
    endtask

    // Inputs are set at a falling edge; this predicts the next rising edge,
    // lets it happen and checks the registered outputs at the following
    // falling edge. fire reports whether the long-path offer was taken.
    task automatic step_cycle(output bit fire);
        bit          ready_exp, have, is_long, bypass;
        logic [4:0]  w_rd;
        logic [31:0] w_data;
        logic [36:0] e;
        #1;
        ready_exp = (m_q.size() < DEPTH);
        check_eq("lsu_ready", {31'b0, lsu_if.ready}, {31'b0, ready_exp});
        fire    = lsu_if.valid && ready_exp;
        have    = 0;
        is_long = 0;
        bypass  = 0;
        w_rd    = '0;
        w_data  = '0;
        if (alu_valid) begin
            have = 1; w_rd = alu_rd; w_data = alu_data;
        end else if (m_q.size() > 0) begin
            e = m_q.pop_front();
            have = 1; is_long = 1; w_rd = e[36:32]; w_data = e[31:0];
        end else if (fire) begin
            have = 1; is_long = 1; bypass = 1; w_rd = lsu_if.rd; w_data = lsu_if.data;
        end
        if (fire && !bypass) m_q.push_back({lsu_if.rd, lsu_if.data});
`ifdef WB_FORWARD_EN
        check_eq("fwd_valid", {31'b0, fwd_valid}, {31'b0, (have && w_rd != 0)});
        if (have && w_rd != 0) begin
            check_eq("fwd_rd", {27'b0, fwd_rd}, {27'b0, w_rd});
            check_eq("fwd_data", fwd_data, w_data);
        end
`endif
        m_write = have && (w_rd != 0);
        if (m_write) begin
            m_waddr = w_rd;
            m_wdata = w_data;
        end
        if (have && is_long) m_busy[w_rd] = 1'b0;
        if (issue_valid && issue_long) m_busy[issue_rd] = 1'b1;
        m_busy[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("write", {31'b0, write}, {31'b0, m_write});
        check_eq("waddr", {27'b0, waddr}, {27'b0, m_waddr});
        check_eq("wdata", wdata, m_wdata);
        check_eq("busy", busy, m_busy);
    endtask

    // ---------------- drivers ----------------
    task automatic drive_idle();
        issue_valid  = 0; issue_long = 0; issue_rd = '0;
        alu_valid    = 0; alu_rd = '0; alu_data = '0;
        lsu_if.valid = 0; lsu_if.rd = '0; lsu_if.data = '0;
    endtask

    task automatic idle_cycles(input int n);
        bit f;
        for (int i = 0; i < n; i++) begin
            drive_idle();
            step_cycle(f);
        end
    endtask

    task automatic issue_long_op(input logic [4:0] rd);
        bit f;
        drive_idle();
        issue_valid = 1; issue_long = 1; issue_rd = rd;
        step_cycle(f);
    endtask

    // ---------------- stimulus ----------------
    logic [4:0]  exp_q[$];
    logic [4:0]  got_q[$];
    logic [31:0] busy_before;
    bit          fire;
    int          off;
    bit          hold;
    int          alu_pct;

    initial begin
        drive_idle();
        repeat (3) @(negedge clk);
        // Reset values while in reset.
        check_eq("rst_write", {31'b0, write}, 32'd0);
        check_eq("rst_waddr", {27'b0, waddr}, 32'd0);
        check_eq("rst_wdata", wdata, 32'd0);
        check_eq("rst_busy", busy, 32'd0);
        rst_n = 1;
        model_reset();

        // 1. single ALU write, then idle
        drive_idle();
        alu_valid = 1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        step_cycle(fire);
        check_eq("alu_write", {31'b0, write}, 32'd1);
        check_eq("alu_waddr", {27'b0, waddr}, 32'd5);
        check_eq("alu_wdata", wdata, 32'hDEADBEEF);
        idle_cycles(1);
        check_eq("alu_idle_write", {31'b0, write}, 32'd0);

        // 2. long op to x7 committed through bypass
        issue_long_op(5'd7);
        check_eq("busy7_set", {31'b0, busy[7]}, 32'd1);
        drive_idle();
        lsu_if.valid = 1; lsu_if.rd = 5'd7; lsu_if.data = 32'h1234;
        step_cycle(fire);
        check_eq("bypass_fire", {31'b0, fire}, 32'd1);
        check_eq("bypass_write", {31'b0, write}, 32'd1);
        check_eq("bypass_waddr", {27'b0, waddr}, 32'd7);
        check_eq("bypass_wdata", wdata, 32'h1234);
        check_eq("busy7_clear", {31'b0, busy[7]}, 32'd0);

        // 3. ALU stalls the long path; long results commit in order
        issue_long_op(5'd1);
        issue_long_op(5'd2);
        issue_long_op(5'd3);
        exp_q = '{5'd1, 5'd2, 5'd3};
        got_q.delete();
        off = 1;
        for (int c = 0; c < 8; c++) begin
            drive_idle();
            alu_valid = (c < 4);
            alu_rd    = 5'(10 + c);
            alu_data  = $urandom;
            lsu_if.valid = (off <= 3);
            lsu_if.rd    = 5'(off);
            lsu_if.data  = 32'h100 + 32'(off);
            if (c == 2) begin
                #1;
                check_eq("stall_ready_low", {31'b0, lsu_if.ready}, 32'd0);
            end
            step_cycle(fire);
            if (fire) off++;
            if (write && waddr >= 1 && waddr <= 3) got_q.push_back(waddr);
        end
        check_eq("order_count", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check_eq("order_rd", {27'b0, got_q[i]}, {27'b0, exp_q[i]});
        check_eq("order_busy_clear", busy & 32'hE, 32'd0);

        // 4. x0 writes from both producers are dropped
        busy_before = busy;
        drive_idle();
        alu_valid = 1; alu_rd = 5'd0; alu_data = 32'hAAAA5555;
        lsu_if.valid = 1; lsu_if.rd = 5'd0; lsu_if.data = 32'h5555AAAA;
        step_cycle(fire);
        check_eq("x0_fire", {31'b0, fire}, 32'd1);
        check_eq("x0_alu_write", {31'b0, write}, 32'd0);
        idle_cycles(1);
        check_eq("x0_lsu_write", {31'b0, write}, 32'd0);
        check_eq("x0_busy", busy, busy_before);

        // 5. same-cycle set and clear of x9: set wins
        issue_long_op(5'd9);
        drive_idle();
        issue_valid = 1; issue_long = 1; issue_rd = 5'd9;
        lsu_if.valid = 1; lsu_if.rd = 5'd9; lsu_if.data = 32'h9999;
        step_cycle(fire);
        check_eq("setwin_write", {31'b0, write}, 32'd1);
        check_eq("setwin_waddr", {27'b0, waddr}, 32'd9);
        check_eq("setwin_busy9", {31'b0, busy[9]}, 32'd1);

        // 6. reset with two FIFO entries pending
        issue_long_op(5'd20);
        issue_long_op(5'd21);
        off = 20;
        for (int c = 0; c < 3; c++) begin
            drive_idle();
            alu_valid = 1; alu_rd = 5'(12 + c); alu_data = $urandom;
            lsu_if.valid = (off <= 21);
            lsu_if.rd    = 5'(off);
            lsu_if.data  = $urandom;
            step_cycle(fire);
            if (fire) off++;
        end
        check_eq("pre_rst_full", {31'b0, lsu_if.ready}, 32'd0);
        drive_idle();
        #2 rst_n = 0;
        #1;
        check_eq("mid_rst_busy", busy, 32'd0);
        check_eq("mid_rst_write", {31'b0, write}, 32'd0);
        check_eq("mid_rst_ready", {31'b0, lsu_if.ready}, 32'd1);
        @(negedge clk);
        rst_n = 1;
        model_reset();
        idle_cycles(4);

        // 7. randomized traffic
        hold = 0;
        drive_idle();
        for (int c = 0; c < 3000; c++) begin
            alu_pct = ((c / 200) % 3 == 0) ? 85 : (((c / 200) % 3 == 1) ? 40 : 10);
            alu_valid = ($urandom_range(0, 99) < alu_pct);
            alu_rd    = 5'($urandom_range(0, 31));
            alu_data  = $urandom;
            issue_valid = ($urandom_range(0, 3) == 0);
            issue_rd    = 5'($urandom_range(0, 31));
            issue_long  = ($urandom_range(0, 1) == 1) && !m_busy[issue_rd];
            if (!hold) begin
                lsu_if.valid = ($urandom_range(0, 2) != 0);
                lsu_if.rd    = 5'($urandom_range(0, 31));
                lsu_if.data  = $urandom;
            end
            step_cycle(fire);
            hold = lsu_if.valid && !fire;
        end
        drive_idle();
        idle_cycles(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
